// File: rtl/mips_controller_pkg.sv
// Shared encodings for the TinyMIPS multicycle controller: states, opcodes, functs,
// ALU op classes, alucontrol codes and the bundled control-word struct.
package mips_controller_pkg;

  typedef enum logic [3:0] {
    FETCH1  = 4'd0,
    FETCH2  = 4'd1,
    FETCH3  = 4'd2,
    FETCH4  = 4'd3,
    DECODE  = 4'd4,
    MEMADR  = 4'd5,
    LBRD    = 4'd6,
    LBWR    = 4'd7,
    SBWR    = 4'd8,
    RTYPEEX = 4'd9,
    RTYPEWR = 4'd10,
    BEQEX   = 4'd11,
    JEX     = 4'd12,
    ADDIEX  = 4'd13,
    ADDIWR  = 4'd14
  } state_t;

  localparam logic [5:0] OP_LB    = 6'b100000;
  localparam logic [5:0] OP_SB    = 6'b101000;
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_ADDI  = 6'b001000;

  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_AND = 6'b100100;
  localparam logic [5:0] FN_OR  = 6'b100101;
  localparam logic [5:0] FN_SLT = 6'b101010;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_SLT = 3'b111;

  typedef struct packed {
    logic [1:0] aluop;
    logic       alusrca;
    logic [1:0] alusrcb;
    logic       iord;
    logic [3:0] irwrite;
    logic       memtoreg;
    logic       memread;
    logic       memwrite;
    logic       pcwrite;
    logic       branch;
    logic [1:0] pcsource;
    logic       regdst;
    logic       regwrite;
  } ctrl_t;

endpackage

// File: rtl/mips_controller_alu_decoder.sv
// Combinational ALU decoder: ALU op class plus funct field -> 3-bit alucontrol.
import mips_controller_pkg::*;

module alu_decoder (
  input  logic [1:0] aluop,
  input  logic [5:0] funct,
  output logic [2:0] alucontrol
);

  always_comb begin
    alucontrol = ALU_ADD;
    case (aluop)
      ALUOP_SUB: alucontrol = ALU_SUB;
      ALUOP_FUNCT: begin
        case (funct)
          FN_ADD:  alucontrol = ALU_ADD;
          FN_SUB:  alucontrol = ALU_SUB;
          FN_AND:  alucontrol = ALU_AND;
          FN_OR:   alucontrol = ALU_OR;
          FN_SLT:  alucontrol = ALU_SLT;
          default: alucontrol = ALU_ADD;
        endcase
      end
      default: alucontrol = ALU_ADD;
    endcase
  end

endmodule

// File: rtl/mips_controller.sv
// Multicycle Moore control FSM for the 8-bit TinyMIPS core: byte-serial fetch,
// decode, then lb/sb/R-type/beq/j/addi execution; pcen also looks at zero.
import mips_controller_pkg::*;

module mips_controller (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] op,
  input  logic [5:0] funct,
  input  logic       zero,
  output logic [2:0] alucontrol,
  output logic       alusrca,
  output logic [1:0] alusrcb,
  output logic       iord,
  output logic [3:0] irwrite,
  output logic       memtoreg,
  output logic       memread,
  output logic       memwrite,
  output logic       pcen,
  output logic [1:0] pcsource,
  output logic       regdst,
  output logic       regwrite
);

  state_t state, nxt;
  ctrl_t  c;
  logic   is_sb;

  // lb/sb choice is captured in DECODE so MEMADR does not depend on op later.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= FETCH1;
      is_sb <= 1'b0;
    end else begin
      state <= nxt;
      if (state == DECODE) is_sb <= (op == OP_SB);
    end
  end

  always_comb begin
    nxt = FETCH1;
    c   = '0;
    c.aluop = ALUOP_ADD;
    case (state)
      FETCH1, FETCH2, FETCH3, FETCH4: begin
        c.memread = 1'b1;
        c.alusrcb = 2'b01;
        c.pcwrite = 1'b1;
        c.irwrite = 4'b0001 << state[1:0];
        nxt = (state == FETCH4) ? DECODE : state_t'(state + 4'd1);
      end
      DECODE: begin
        c.alusrcb = 2'b11;
        case (op)
          OP_LB, OP_SB: nxt = MEMADR;
          OP_RTYPE:     nxt = RTYPEEX;
          OP_BEQ:       nxt = BEQEX;
          OP_J:         nxt = JEX;
          OP_ADDI:      nxt = ADDIEX;
          default:      nxt = FETCH1;
        endcase
      end
      MEMADR: begin
        c.alusrca = 1'b1;
        c.alusrcb = 2'b10;
        nxt = is_sb ? SBWR : LBRD;
      end
      LBRD: begin
        c.memread = 1'b1;
        c.iord    = 1'b1;
        nxt = LBWR;
      end
      LBWR: begin
        c.regwrite = 1'b1;
        c.memtoreg = 1'b1;
      end
      SBWR: begin
        c.memwrite = 1'b1;
        c.iord     = 1'b1;
      end
      RTYPEEX: begin
        c.alusrca = 1'b1;
        c.aluop   = ALUOP_FUNCT;
        nxt = RTYPEWR;
      end
      RTYPEWR: begin
        c.regwrite = 1'b1;
        c.regdst   = 1'b1;
      end
      BEQEX: begin
        c.alusrca  = 1'b1;
        c.aluop    = ALUOP_SUB;
        c.branch   = 1'b1;
        c.pcsource = 2'b01;
      end
      JEX: begin
        c.pcwrite  = 1'b1;
        c.pcsource = 2'b10;
      end
      ADDIEX: begin
        c.alusrca = 1'b1;
        c.alusrcb = 2'b10;
        nxt = ADDIWR;
      end
      ADDIWR: c.regwrite = 1'b1;
      default: nxt = FETCH1;
    endcase
  end

  alu_decoder u_aludec (
    .aluop      (c.aluop),
    .funct      (funct),
    .alucontrol (alucontrol)
  );

  // Strobes are squashed combinationally while reset is held low.
  assign alusrca  = c.alusrca;
  assign alusrcb  = c.alusrcb;
  assign iord     = c.iord;
  assign memtoreg = c.memtoreg;
  assign pcsource = c.pcsource;
  assign regdst   = c.regdst;
  assign irwrite  = reset ? c.irwrite : 4'b0000;
  assign memread  = reset & c.memread;
  assign memwrite = reset & c.memwrite;
  assign regwrite = reset & c.regwrite;
  assign pcen     = reset & (c.pcwrite | (c.branch & zero));

endmodule
